// File: rtl/queue_pkg.sv
// Shared types for the register-file queue egress stage.
package queue_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } egress_state_t;

endpackage

// File: rtl/queue_rf_egress_if.sv
// Queue-pop side and consumer stream side of the egress stage.
interface queue_rf_egress_if #(parameter int W = 32);

    logic         i_q_empty_w;
    logic [W-1:0] i_q_dat;
    logic         o_q_pop;
    logic         o_valid;
    logic [W-1:0] o_dat;
    logic         i_ready;

    modport master (
        input  i_q_empty_w, i_q_dat, i_ready,
        output o_q_pop, o_valid, o_dat
    );

    modport slave (
        output i_q_empty_w, i_q_dat, i_ready,
        input  o_q_pop, o_valid, o_dat
    );

endinterface

// File: rtl/queue_rf_egress.sv
// Drains the register-file queue into a registered valid/ready stream via a
// 2-entry skid buffer; the pop strobe never sees the consumer's ready.
module queue_rf_egress
    import queue_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    queue_rf_egress_if.master   bus
);

    egress_state_t state_q, state_d;
    logic [W-1:0]  head_q, skid_q;
    logic          fill, drain, valid;

    // Pop only when there is room for the returning head; ready is not involved.
    assign fill  = !rst && !bus.i_q_empty_w && (state_q != TWO);
    assign valid = (state_q != EMPTY);
    assign drain = valid && bus.i_ready;

    assign bus.o_q_pop = fill;
    assign bus.o_valid = valid;
    assign bus.o_dat   = head_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (fill) state_d = ONE;
            ONE: begin
                if (fill && !drain)      state_d = TWO;
                else if (!fill && drain) state_d = EMPTY;
            end
            TWO:   if (drain) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Data flops carry no reset; occupancy alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill && (state_q == EMPTY || (state_q == ONE && drain)))
            head_q <= bus.i_q_dat;
        else if (state_q == TWO && drain)
            head_q <= skid_q;
        if (fill && state_q == ONE && !drain)
            skid_q <= bus.i_q_dat;
    end

`ifndef SYNTHESIS
    a_pop_nonempty: assert property (@(posedge clk) bus.o_q_pop |-> !bus.i_q_empty_w);
    a_hold: assert property (@(posedge clk)
        (!rst && valid && !bus.i_ready) |=> (valid && $stable(head_q)));
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        logic'(state_q[1] & state_q[0]) == 1'b0);
`endif

endmodule

// File: tb/tb_queue_rf_egress.sv
// Scoreboard bench for queue_rf_egress with a behavioural upstream queue.
module tb_queue_rf_egress;
    import queue_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_rf_egress_if #(.W(W)) bus();

    queue_rf_egress #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [W-1:0] src[$];
    logic [W-1:0] sb[$];
    int           n_buf;
    int           vectors, miscompares;
    logic         s_pop, s_valid, s_rst;
    logic [W-1:0] s_dat;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic drive_q();
        bus.i_q_empty_w = (src.size() == 0);
        bus.i_q_dat     = (src.size() != 0) ? src[0] : '0;
    endtask

    task automatic push(input logic [W-1:0] v);
        src.push_back(v);
        sb.push_back(v);
        drive_q();
    endtask

    // One clock: sample/score at negedge, then advance the upstream model.
    task automatic cyc();
        logic [W-1:0] exp;
        drive_q();
        @(negedge clk);
        s_pop   = bus.o_q_pop;
        s_valid = bus.o_valid;
        s_dat   = bus.o_dat;
        s_rst   = rst;
        if (s_pop) chk("pop_nonempty", W'(bus.i_q_empty_w), '0);
        if (!s_rst && s_valid === 1'b1 && bus.i_ready) begin
            if (sb.size() == 0) chk("extra_beat", 1, 0);
            else begin
                exp = sb.pop_front();
                chk("dat", s_dat, exp);
            end
            n_buf--;
        end
        @(posedge clk);
        #1;
        if (s_pop && src.size() != 0) begin
            void'(src.pop_front());
            n_buf++;
        end
        if (s_rst) begin
            for (int k = 0; k < n_buf; k++) if (sb.size() != 0) void'(sb.pop_front());
            n_buf = 0;
        end
        drive_q();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops, beats, first, last, pushed, guard;
        vectors = 0; miscompares = 0; n_buf = 0;
        bus.i_ready = 1'b0;
        rst = 1'b1;
        drive_q();

        // reset hold with a non-empty queue
        push(32'h11);
        cyc();
        repeat (3) begin
            cyc();
            chk("rst_valid", W'(s_valid), '0);
            chk("rst_pop", W'(s_pop), '0);
        end
        rst = 1'b0;
        cyc();
        chk("rel_pop", W'(s_pop), 1);
        bus.i_ready = 1'b1;
        repeat (3) cyc();

        // single beat
        push(32'hA5);
        cyc(); chk("sb_pop", W'(s_pop), 1);
        cyc(); chk("sb_valid", W'(s_valid), 1); chk("sb_dat", s_dat, 32'hA5);
        cyc(); chk("sb_empty", W'(s_valid), 0);

        // backpressure fills skid then drains in order
        bus.i_ready = 1'b0;
        push(32'h1); push(32'h2); push(32'h3);
        pops = 0;
        repeat (5) begin cyc(); pops += int'(s_pop); end
        chk("bp_pops", W'(pops), 2);
        chk("bp_valid", W'(s_valid), 1);
        chk("bp_hold", s_dat, 32'h1);
        bus.i_ready = 1'b1;
        cyc(); chk("bp_d1", s_dat, 32'h1); chk("bp_nopop", W'(s_pop), 0);
        cyc(); chk("bp_d2", s_dat, 32'h2); chk("bp_pop3", W'(s_pop), 1);
        cyc(); chk("bp_d3", s_dat, 32'h3); chk("bp_v3", W'(s_valid), 1);
        cyc(); chk("bp_idle", W'(s_valid), 0);

        // streaming, no bubbles after the first beat
        for (int i = 0; i < 16; i++) push(W'(i));
        beats = 0; first = -1; last = -1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (s_valid) begin
                beats++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("st_beats", W'(beats), 16);
        chk("st_span", W'(last - first + 1), 16);

        // reset mid-operation from TWO
        bus.i_ready = 1'b0;
        push(32'h7); push(32'h8); push(32'h9);
        repeat (4) cyc();
        chk("rm_head", s_dat, 32'h7);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("rm_valid", W'(s_valid), 0);
        chk("rm_pop", W'(s_pop), 1);
        bus.i_ready = 1'b1;
        cyc();
        chk("rm_next", s_dat, 32'h9);
        repeat (3) cyc();
        chk("rm_sb", W'(sb.size()), 0);

        // random traffic with random ready
        pushed = 0; guard = 0;
        while (pushed < 1000 && guard < 5000) begin
            if ($urandom_range(1, 0) == 1) begin
                push($urandom);
                pushed++;
            end
            bus.i_ready = $urandom_range(1, 0) == 1;
            cyc();
            guard++;
        end
        chk("rnd_pushed", W'(pushed), 1000);
        bus.i_ready = 1'b1;
        guard = 0;
        while ((sb.size() != 0 || bus.o_valid) && guard < 3000) begin
            cyc();
            guard++;
        end
        chk("rnd_left", W'(sb.size()), 0);
        chk("rnd_src", W'(src.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/queue_rf_egress.md
Name: queue_rf_egress

Overview:
- Downstream stage of the register-file queue: drains the queue's pop interface and presents a registered valid/ready stream to the consumer.
- Uses a 2-entry skid buffer so that o_q_pop never depends combinationally on i_ready.
- Timing isolation: both the consumer's ready path and the queue's read-data path are fully registered at this boundary.

Parameters:
- W, 32: data width; must equal the upstream queue's entry width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_q_empty_w  in  1  upstream queue empty status; combinational, current cycle
- i_q_dat  in  W  upstream queue head data; valid whenever i_q_empty_w=0
- o_q_pop  out  1  pop strobe to upstream queue; head advances at the next clk edge
- o_valid  out  1  output data valid, registered
- o_dat  out  W  output data, registered
- i_ready  in  1  consumer accepts o_dat this cycle when o_valid=1

Behaviour:
- Reset: one clock, synchronous, active-high; rst is sampled on the clk edge.
  - While rst=1: state=EMPTY, o_valid=0, o_q_pop=0.
  - o_dat and skid data are don't-care; no reset is required on the data flops.
- Reset mid-operation: buffered entries are discarded. Upstream queue contents are untouched; the queue's own reset governs them.
- State (occupancy): EMPTY (0), ONE (1), TWO (2). Encoded as a 2-bit enum; value 3 is illegal and gets an assertion.
- Pop rule: o_q_pop = !rst & !i_q_empty_w & (state != TWO).
  - Depends only on registered state and upstream empty, never on i_ready.
  - Must never assert while i_q_empty_w=1.
- Drain: drain = o_valid & i_ready.
- Transitions (fill = o_q_pop):
  - EMPTY: fill -> ONE. Otherwise stay in EMPTY.
  - ONE: fill & !drain -> TWO; fill & drain -> ONE; !fill & drain -> EMPTY; otherwise stay in ONE.
  - TWO: drain -> ONE; otherwise stay in TWO. No fill is possible in TWO.
- Datapath:
  - Head register drives o_dat. Skid register holds the second entry.
  - Fill in EMPTY, or fill & drain in ONE: head <= i_q_dat.
  - Fill & !drain in ONE: skid <= i_q_dat.
  - Drain in TWO: head <= skid.
  - o_valid = (state != EMPTY), taken from registered state.
- Latency: a non-empty queue head appears on o_dat 1 cycle after o_q_pop. A queue written at cycle t (empty at t) gives o_valid at t+2.
- Throughput: with i_ready held at 1 and the queue non-empty, 1 beat per cycle in steady state ONE.
- Stability: while o_valid=1 & i_ready=0, o_dat and o_valid hold. Data is never dropped or duplicated.
- Ordering: strict FIFO order is preserved across the queue and the skid.
- Boundary: queue goes empty while in TWO, then i_ready=1 -> ONE with the skid entry promoted; o_valid stays 1.

Decomposition:
- Shared package (queue_pkg):
  - typedef egress_state_t enum {EMPTY, ONE, TWO}, 2-bit.
  - Occupancy-width constant.
- Single module; no sub-module. The skid pair is small enough to inline.
- Optional top-level wrapper pairing queue_rf with queue_rf_egress is left to integration.
- Assertions:
  - o_q_pop -> !i_q_empty_w.
  - Stability of o_dat while o_valid & !i_ready.
  - State never equals 3.

Test Plan:
- Reset hold: rst=1 for 3 cycles with i_q_empty_w=0 -> o_valid=0 and o_q_pop=0 throughout. Release -> o_q_pop=1 on the first non-reset cycle.
- Single beat: queue holds 0xA5, i_ready=1 -> o_q_pop for 1 cycle, o_valid=1/o_dat=0xA5 next cycle, then EMPTY.
- Backpressure: queue holds 0x1,0x2,0x3, i_ready=0 -> exactly 2 pops, state TWO, o_dat=0x1 stable.
  - Then i_ready=1 -> outputs 0x1,0x2,0x3 on consecutive cycles, with the third pop issued the cycle after the first drain.
- Streaming: 16 entries 0..15 with i_ready=1 -> 16 consecutive valid beats in order, no bubbles after the first.
- Random ready: 1000 entries with ~50% random i_ready -> scoreboard shows in-order output, no loss or duplication, and no pop while empty.
- Reset mid-operation: state TWO (0x7,0x8 buffered), assert rst for 1 cycle -> o_valid=0 next cycle. After release, the next output is the queue's current head, not 0x7 or 0x8.
